memory_transfer_sequencer: RTL and testbench

//  Control-side driver for the ALU system datapath: generates the Mem/IR/DR/ARF/RF/Mux control words for the byte-serial memory transfers.

---
 rtl/memory_transfer_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_memory_transfer_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_transfer_sequencer.sv
// ============================================================================
// memory_transfer_sequencer
//
// Purpose:
//   Control-side driver for the ALU system datapath. Accepts one command at a
//   time from the instruction controller and generates the Mem/IR/DR/ARF/RF/
//   Mux/ALU control words for byte-serial memory transfers:
//     - instruction fetch (two bytes at PC into IR, low byte first)
//     - word load (WORD_BYTES bytes at AR shifted into DR, then DR into RF)
//     - word store (RF word through ALU pass-through, MuxC picks one byte per
//       cycle, most significant byte first, written at AR)
//   All control outputs are registered and depend only on the state, the
//   byte counter and the operands latched on accept.
//
// Ports:
//   Clock, Reset                  rising-edge clock, synchronous active-high reset
//   Cmd_Valid / Cmd_Ready         command handshake (Ready high only when idle)
//   Cmd_Op [1:0]                  00 fetch, 01 load, 10 store, 11 reserved
//   Cmd_Reg [1:0]                 RF register R1..R4
//   Cmd_SP                        (MEMSEQ_SP_EN only) address load/store via SP
//   Done, Err                     one-cycle completion pulse, error with Done
//   Mem_CS, Mem_WR                active-low memory select, 1 = write
//   IR_Write, IR_LH               IR load enable, byte half select
//   DR_E, DR_FunSel               DR enable and function
//   ARF_RegSel/FunSel/OutDSel     address register file control
//   RF_RegSel/FunSel/OutASel      register file control
//   MuxASel, MuxCSel, MuxDSel     datapath multiplexer selects
//   ALU_FunSel, ALU_WF            ALU function, flag write (always 0)
//
// Configuration:
//   MEMSEQ_SP_EN  when defined adds the Cmd_SP input; load/store then address
//                 memory through SP when Cmd_SP was set on accept.
// ============================================================================
module memory_transfer_sequencer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [4:0]  ALU_PASS_A = 5'b10000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Cmd_Valid,
    output logic       Cmd_Ready,
    input  logic [1:0] Cmd_Op,
    input  logic [1:0] Cmd_Reg,
`ifdef MEMSEQ_SP_EN
    input  logic       Cmd_SP,
`endif
    output logic       Done,
    output logic       Err,
    output logic       Mem_CS,
    output logic       Mem_WR,
    output logic       IR_Write,
    output logic       IR_LH,
    output logic       DR_E,
    output logic [1:0] DR_FunSel,
    output logic [2:0] ARF_RegSel,
    output logic [1:0] ARF_FunSel,
    output logic [1:0] ARF_OutDSel,
    output logic [3:0] RF_RegSel,
    output logic [2:0] RF_FunSel,
    output logic [2:0] RF_OutASel,
    output logic [1:0] MuxASel,
    output logic [1:0] MuxCSel,
    output logic       MuxDSel,
    output logic [4:0] ALU_FunSel,
    output logic       ALU_WF
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_L,
        S_FETCH_H,
        S_LOAD_B,
        S_LOAD_WB,
        S_STORE_B,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       cmd_ready;
        logic       done;
        logic       err;
        logic       mem_cs;
        logic       mem_wr;
        logic       ir_write;
        logic       ir_lh;
        logic       dr_e;
        logic [1:0] dr_funsel;
        logic [2:0] arf_regsel;
        logic [1:0] arf_funsel;
        logic [1:0] arf_outdsel;
        logic [3:0] rf_regsel;
        logic [2:0] rf_funsel;
        logic [2:0] rf_outasel;
        logic [1:0] muxasel;
        logic [1:0] muxcsel;
        logic       muxdsel;
        logic [4:0] alu_funsel;
        logic       alu_wf;
    } ctrl_t;

    // Index of the last byte; also the first MuxC byte select of a store.
    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [1:0] reg_q, reg_d;
    logic       sp_q, sp_d;
    logic       cmd_sp;
    ctrl_t      ctrl_q, ctrl_d;

`ifdef MEMSEQ_SP_EN
    assign cmd_sp = Cmd_SP;
`else
    assign cmd_sp = 1'b0;
`endif

    // Control word for a given state. Everything not explicitly driven stays
    // 0, which leaves memory deselected and all register files holding.
    function automatic ctrl_t decode(input state_t st, input logic [1:0] cnt,
                                     input logic [1:0] op, input logic [1:0] rg,
                                     input logic sp);
        ctrl_t c;
        c        = '0;
        c.mem_cs = 1'b1;
        case (st)
            S_IDLE: c.cmd_ready = 1'b1;
            S_FETCH_L, S_FETCH_H: begin
                c.mem_cs      = 1'b0;
                c.ir_write    = 1'b1;
                c.ir_lh       = (st == S_FETCH_H);
                c.arf_outdsel = 2'b00;
                c.arf_regsel  = 3'b100;
                c.arf_funsel  = 2'b01;
            end
            S_LOAD_B: begin
                c.mem_cs      = 1'b0;
                c.dr_e        = 1'b1;
                c.dr_funsel   = 2'b10;
                c.arf_outdsel = sp ? 2'b01 : 2'b10;
                c.arf_regsel  = sp ? 3'b001 : 3'b010;
                c.arf_funsel  = 2'b01;
            end
            S_LOAD_WB: begin
                c.muxasel   = 2'b10;
                c.rf_funsel = 3'b010;
                c.rf_regsel = 4'b1000 >> rg;
            end
            S_STORE_B: begin
                // Big-endian: byte select counts down from the MSB.
                c.rf_outasel  = {1'b0, rg};
                c.muxdsel     = 1'b0;
                c.alu_funsel  = ALU_PASS_A;
                c.muxcsel     = LAST_IDX - cnt;
                c.mem_cs      = 1'b0;
                c.mem_wr      = 1'b1;
                c.arf_outdsel = sp ? 2'b01 : 2'b10;
                c.arf_regsel  = sp ? 3'b001 : 3'b010;
                c.arf_funsel  = 2'b01;
            end
            S_DONE: begin
                c.done = 1'b1;
                c.err  = (op == 2'b11);
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state logic. The control word is decoded from the next state so
    // that the registered outputs line up with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        reg_d   = reg_q;
        sp_d    = sp_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Cmd_Valid) begin
                    op_d  = Cmd_Op;
                    reg_d = Cmd_Reg;
                    sp_d  = cmd_sp;
                    case (Cmd_Op)
                        2'b00:   state_d = S_FETCH_L;
                        2'b01:   state_d = S_LOAD_B;
                        2'b10:   state_d = S_STORE_B;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_FETCH_L: state_d = S_FETCH_H;
            S_FETCH_H: state_d = S_DONE;
            S_LOAD_B: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_WB;
                end
            end
            S_LOAD_WB: state_d = S_DONE;
            S_STORE_B: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ctrl_d = decode(state_d, cnt_d, op_d, reg_d, sp_d);
    end

    // State, operand and output registers. Reset takes effect at the edge,
    // so the cycle with Reset high still drives the current control word.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            reg_q   <= '0;
            sp_q    <= 1'b0;
            ctrl_q  <= decode(S_IDLE, 2'b00, 2'b00, 2'b00, 1'b0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            reg_q   <= reg_d;
            sp_q    <= sp_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign Cmd_Ready   = ctrl_q.cmd_ready;
    assign Done        = ctrl_q.done;
    assign Err         = ctrl_q.err;
    assign Mem_CS      = ctrl_q.mem_cs;
    assign Mem_WR      = ctrl_q.mem_wr;
    assign IR_Write    = ctrl_q.ir_write;
    assign IR_LH       = ctrl_q.ir_lh;
    assign DR_E        = ctrl_q.dr_e;
    assign DR_FunSel   = ctrl_q.dr_funsel;
    assign ARF_RegSel  = ctrl_q.arf_regsel;
    assign ARF_FunSel  = ctrl_q.arf_funsel;
    assign ARF_OutDSel = ctrl_q.arf_outdsel;
    assign RF_RegSel   = ctrl_q.rf_regsel;
    assign RF_FunSel   = ctrl_q.rf_funsel;
    assign RF_OutASel  = ctrl_q.rf_outasel;
    assign MuxASel     = ctrl_q.muxasel;
    assign MuxCSel     = ctrl_q.muxcsel;
    assign MuxDSel     = ctrl_q.muxdsel;
    assign ALU_FunSel  = ctrl_q.alu_funsel;
    assign ALU_WF      = ctrl_q.alu_wf;

endmodule

// File: tb/tb_memory_transfer_sequencer.sv
// ============================================================================
// tb_memory_transfer_sequencer
//
// Drives commands into memory_transfer_sequencer and runs a small datapath
// (memory, PC/AR/SP, R1..R4, IR, DR) off its control outputs. Each issued
// command pushes its expected outcome, worked out from the transfer rules,
// onto a scoreboard; a monitor pops it when Done pulses and compares the
// datapath results, Err and the completion latency.
// ============================================================================
module tb_memory_transfer_sequencer;

    localparam int W = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [1:0] Cmd_Op;
    logic [1:0] Cmd_Reg;
`ifdef MEMSEQ_SP_EN
    logic       Cmd_SP;
`endif
    logic       Done, Err, Mem_CS, Mem_WR, IR_Write, IR_LH, DR_E, MuxDSel, ALU_WF;
    logic [1:0] DR_FunSel, ARF_FunSel, ARF_OutDSel, MuxASel, MuxCSel;
    logic [2:0] ARF_RegSel, RF_FunSel, RF_OutASel;
    logic [3:0] RF_RegSel;
    logic [4:0] ALU_FunSel;

    memory_transfer_sequencer #(.WORD_BYTES(W), .ALU_PASS_A(5'b10000)) dut (
        .Clock(Clock), .Reset(Reset),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Op(Cmd_Op), .Cmd_Reg(Cmd_Reg),
`ifdef MEMSEQ_SP_EN
        .Cmd_SP(Cmd_SP),
`endif
        .Done(Done), .Err(Err), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
        .IR_Write(IR_Write), .IR_LH(IR_LH), .DR_E(DR_E), .DR_FunSel(DR_FunSel),
        .ARF_RegSel(ARF_RegSel), .ARF_FunSel(ARF_FunSel), .ARF_OutDSel(ARF_OutDSel),
        .RF_RegSel(RF_RegSel), .RF_FunSel(RF_FunSel), .RF_OutASel(RF_OutASel),
        .MuxASel(MuxASel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
        .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  rg;
        logic        use_sp;
        int          lat;
        int          accept_cycle;
        logic [15:0] exp_pc;
        logic [15:0] exp_ir;
        logic [15:0] exp_addr;
        logic [15:0] base;
        logic [31:0] exp_word;
    } item_t;

    item_t       sb_q[$];
    logic [7:0]  mem [0:65535];
    logic [15:0] pc, ar, sp, ir;
    logic [31:0] dr;
    logic [31:0] rf [4];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle_cnt = 0;
    logic        held_prev = 1'b0;
    int          prev_accept = 0;
    int          prev_lat = 0;

    // Free-running clock, 10 time units per cycle.
    always #5 Clock = ~Clock;

    // Cycle counter used to measure accept-to-Done latency.
    always @(posedge Clock) cycle_cnt++;

    // Datapath stand-in: applies the control word present just before each
    // rising edge. Memory reads are combinational on the selected address,
    // and capture/increment/write all land on the same edge.
    always @(posedge Clock) begin
        logic [15:0] addr;
        logic [31:0] alu;
        logic [7:0]  rd;
        case (ARF_OutDSel)
            2'b00:   addr = pc;
            2'b10:   addr = ar;
            2'b01:   addr = sp;
            default: addr = 16'h0000;
        endcase
        if (Mem_CS === 1'b0 && Mem_WR === 1'b0) begin
            rd = mem[addr];
            if (IR_Write === 1'b1) begin
                if (IR_LH === 1'b1) ir[15:8] = rd;
                else ir[7:0] = rd;
            end
            if (DR_E === 1'b1 && DR_FunSel === 2'b10) dr = {dr[23:0], rd};
        end
        if (Mem_CS === 1'b0 && Mem_WR === 1'b1) begin
            if (MuxDSel === 1'b0 && ALU_FunSel === 5'b10000 && RF_OutASel[2] === 1'b0)
                alu = rf[RF_OutASel[1:0]];
            else
                alu = 32'hDEADBEEF;
            mem[addr] = alu[int'(MuxCSel) * 8 +: 8];
        end
        if (ARF_FunSel === 2'b01) begin
            if (ARF_RegSel[2] === 1'b1) pc = pc + 16'd1;
            if (ARF_RegSel[1] === 1'b1) ar = ar + 16'd1;
            if (ARF_RegSel[0] === 1'b1) sp = sp + 16'd1;
        end
        if (RF_FunSel === 3'b010 && MuxASel === 2'b10) begin
            for (int i = 0; i < 4; i++) if (RF_RegSel[3 - i] === 1'b1) rf[i] = dr;
        end
    end

    // One comparison: counts it, and reports a FAIL line on any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: on every Done pulse, pop the oldest expectation
    // and check latency, Err and the transfer's effect on the datapath.
    always @(negedge Clock) begin
        item_t       it;
        logic [31:0] act;
        if (Done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                it = sb_q.pop_front();
                // Latency counts the first cycle after the accept edge as 1.
                checkOutput("latency", 32'(cycle_cnt - it.accept_cycle + 1), 32'(it.lat));
                checkOutput("err", 32'(Err), 32'(it.op == 2'b11));
                checkOutput("ready_in_done", 32'(Cmd_Ready), 32'd0);
                checkOutput("alu_wf", 32'(ALU_WF), 32'd0);
                checkOutput("addr_reg", 32'(it.use_sp ? sp : ar), 32'(it.exp_addr));
                case (it.op)
                    2'b00: begin
                        checkOutput("fetch_ir", 32'(ir), 32'(it.exp_ir));
                        checkOutput("fetch_pc", 32'(pc), 32'(it.exp_pc));
                    end
                    2'b01: checkOutput("load_rf", rf[it.rg], it.exp_word);
                    2'b10: begin
                        act = 32'd0;
                        for (int i = 0; i < W; i++) act = {act[23:0], mem[it.base + 16'(i)]};
                        checkOutput("store_mem", act, it.exp_word);
                    end
                    default: checkOutput("reserved_pc", 32'(pc), 32'(it.exp_pc));
                endcase
            end
        end else if (Err === 1'b1) begin
            checkOutput("err_without_done", 32'd1, 32'd0);
        end
    end

    // Issue one command once the sequencer is idle, record what it should
    // do, and optionally keep Cmd_Valid asserted (with scrambled operands)
    // while it is busy.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] rg,
                                 input logic use_sp, input logic keep_valid);
        item_t       it;
        int          guard;
        logic [15:0] a;
        guard = 0;
        @(negedge Clock);
        while (Cmd_Ready !== 1'b1 && guard < 40) begin
            @(negedge Clock);
            guard++;
        end
        if (guard >= 40) begin
            checkOutput("ready_timeout", 32'(Cmd_Ready), 32'd1);
            Cmd_Valid = 1'b0;
            held_prev = 1'b0;
            return;
        end
        it.op       = op;
        it.rg       = rg;
        it.use_sp   = (op == 2'b01 || op == 2'b10) ? use_sp : 1'b0;
        a           = it.use_sp ? sp : ar;
        it.base     = a;
        it.exp_pc   = pc;
        it.exp_ir   = ir;
        it.exp_addr = a;
        it.exp_word = rf[rg];
        case (op)
            2'b00: begin
                it.lat    = 3;
                it.exp_ir = {mem[pc + 16'd1], mem[pc]};
                it.exp_pc = pc + 16'd2;
            end
            2'b01: begin
                it.lat      = W + 2;
                it.exp_word = dr;
                for (int i = 0; i < W; i++) it.exp_word = {it.exp_word[23:0], mem[a + 16'(i)]};
                it.exp_addr = a + 16'(W);
            end
            2'b10: begin
                it.lat      = W + 1;
                it.exp_addr = a + 16'(W);
            end
            default: it.lat = 1;
        endcase
        Cmd_Op    = op;
        Cmd_Reg   = rg;
        Cmd_Valid = 1'b1;
`ifdef MEMSEQ_SP_EN
        Cmd_SP    = use_sp;
`endif
        @(posedge Clock);
        #1;
        it.accept_cycle = cycle_cnt;
        if (held_prev)
            checkOutput("held_accept_cycle", 32'(cycle_cnt), 32'(prev_accept + prev_lat + 1));
        sb_q.push_back(it);
        held_prev   = keep_valid;
        prev_accept = cycle_cnt;
        prev_lat    = it.lat;
        if (keep_valid) begin
            Cmd_Op  = ~op;
            Cmd_Reg = ~rg;
        end else begin
            Cmd_Valid = 1'b0;
        end
    endtask

    // Wait (bounded) until every issued command has completed.
    task automatic waitDrain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge Clock);
            guard++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge Clock);
    endtask

    // Main sequence: reset, directed transfers, reset mid-store, random mix.
    initial begin
        logic [1:0] op;
        logic       use_sp;
        Reset     = 1'b1;
        Cmd_Valid = 1'b0;
        Cmd_Op    = 2'b00;
        Cmd_Reg   = 2'b00;
`ifdef MEMSEQ_SP_EN
        Cmd_SP    = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) rf[i] = $urandom;
        pc = 16'h0000; ar = 16'h0000; sp = 16'h0000; ir = 16'h0000; dr = 32'h0;

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkOutput("reset_cmd_ready", 32'(Cmd_Ready), 32'd1);
        checkOutput("reset_mem_cs", 32'(Mem_CS), 32'd1);
        checkOutput("reset_arf_regsel", 32'(ARF_RegSel), 32'd0);
        checkOutput("reset_rf_regsel", 32'(RF_RegSel), 32'd0);
        checkOutput("reset_done", 32'(Done), 32'd0);
        checkOutput("reset_err", 32'(Err), 32'd0);
        Reset = 1'b0;

        pc = 16'h0010; mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        waitDrain();
        checkOutput("fetch_ir_1234", 32'(ir), 32'h0000_1234);
        checkOutput("fetch_pc_0012", 32'(pc), 32'h0000_0012);

        ar = 16'h0020;
        mem[16'h0020] = 8'hAA; mem[16'h0021] = 8'hBB; mem[16'h0022] = 8'hCC; mem[16'h0023] = 8'hDD;
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
        waitDrain();
        checkOutput("load_r2_value", rf[1], 32'hAABBCCDD);
        checkOutput("load_ar_0024", 32'(ar), 32'h0000_0024);

        rf[2] = 32'h11223344; ar = 16'h0040;
        applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
        waitDrain();
        checkOutput("store_mem_40_43", {mem[16'h0040], mem[16'h0041], mem[16'h0042], mem[16'h0043]},
                    32'h11223344);
        checkOutput("store_ar_0044", 32'(ar), 32'h0000_0044);

        applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b11, 1'b0, 1'b1);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        waitDrain();

        // Reset during the third byte cycle of a store.
        rf[2] = 32'h11223344; ar = 16'h0040;
        for (int i = 0; i < 4; i++) mem[16'h0040 + 16'(i)] = 8'hEE;
        Cmd_Op = 2'b10; Cmd_Reg = 2'b10; Cmd_Valid = 1'b1;
        @(posedge Clock);
        #1 Cmd_Valid = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        checkOutput("rst_mem_40_42", {8'h00, mem[16'h0040], mem[16'h0041], mem[16'h0042]}, 32'h00112233);
        checkOutput("rst_mem_43", 32'(mem[16'h0043]), 32'h0000_00EE);
        checkOutput("rst_ar", 32'(ar), 32'h0000_0043);
        checkOutput("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);
        repeat (6) @(negedge Clock);

        ar = 16'hFFFE;
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        waitDrain();

        for (int n = 0; n < 40; n++) begin
            if (!held_prev) begin
                waitDrain();
                pc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                ar = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
                sp = 16'($urandom);
                rf[$urandom_range(0, 3)] = $urandom;
            end
            op = 2'($urandom_range(0, 3));
`ifdef MEMSEQ_SP_EN
            use_sp = 1'($urandom_range(0, 1));
`else
            use_sp = 1'b0;
`endif
            applyStimulus(op, 2'($urandom_range(0, 3)), use_sp,
                          (n != 39) && ($urandom_range(0, 3) == 0));
        end
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Time limit so a stuck handshake still ends with a summary.
    initial begin
        #200000;
        compared++;
        mismatched++;
        $display("[TB] FAIL watchdog: got time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
